// File: rtl/mem_access_stage.sv
// Memory stage: owns the stack pointer, drives the 16-bit data memory and splits 32-bit accesses over two cycles.
// Optional stack bounds checking is enabled by defining STACK_CHECK_EN.
module mem_access_stage #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_type_in,
  input  logic [1:0]        SP_src_in,
  input  logic              mem_addr_src_in,
  input  logic              mem_data_src_in,
  input  logic              flags_push_pop_in,
  input  logic [15:0]       Rsrc_val_in,
  input  logic [15:0]       Rdst_val_in,
  input  logic [31:0]       PC_in,
  input  logic [15:0]       Rdst1_val_in,
  input  logic [15:0]       Rdst2_val_in,
  input  logic [2:0]        Rdst1_in,
  input  logic [2:0]        Rdst2_in,
  input  logic              reglow_write_in,
  input  logic              reghigh_write_in,
  input  logic              memToReg_in,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [15:0]       dmem_rdata,
  output logic              stall_out,
  output logic              wb_valid_out,
  output logic              reglow_write_out,
  output logic              reghigh_write_out,
  output logic              memToReg_out,
  output logic [2:0]        Rdst1_out,
  output logic [2:0]        Rdst2_out,
  output logic [15:0]       Rdst1_val_out,
  output logic [15:0]       Rdst2_val_out,
  output logic [15:0]       mem_data_out,
  output logic [2:0]        POP_flags_val_out,
  output logic              is_POP_flags_out,
  output logic [31:0]       pop_pc_out,
  output logic              pop_pc_valid_out,
  output logic [ADDR_W-1:0] SP_out,
  output logic              stack_exc_out
);

  typedef enum logic {IDLE, SECOND} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] sp, sp_nxt;
  logic [15:0]       low_word_p1;

  logic              is_push, is_pop, wr, rd, exc, go, complete;
  logic [ADDR_W-1:0] rsrc_addr, first_addr, second_addr;
  logic [31:0]       data32;
  logic [15:0]       first_wdata, second_wdata;

  assign is_push   = (SP_src_in == 2'd1);
  assign is_pop    = (SP_src_in == 2'd2);
  // Write wins over read if a malformed control word asserts both
  assign wr        = valid_in & mem_write_in;
  assign rd        = valid_in & mem_read_in & ~mem_write_in;
  assign rsrc_addr = ADDR_W'(Rsrc_val_in);
  assign data32    = mem_data_src_in ? PC_in : {16'h0000, Rdst_val_in};

  always_comb begin
    first_addr  = mem_addr_src_in ? rsrc_addr : sp;
    second_addr = first_addr + ONE;
    if (is_push) begin
      first_addr  = sp;
      second_addr = sp - ONE;
    end else if (is_pop) begin
      first_addr  = sp + ONE;
      second_addr = sp + TWO;
    end
  end

  // Push stores high word first so it lands above the low word on the stack
  assign first_wdata  = (mem_type_in & is_push) ? data32[31:16] : data32[15:0];
  assign second_wdata = is_push ? data32[15:0] : data32[31:16];

`ifdef STACK_CHECK_EN
  logic [ADDR_W:0] need, sp_ext;
  assign need   = mem_type_in ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
  assign sp_ext = {1'b0, sp};
  assign exc    = valid_in & (state == IDLE) &
                  ((is_pop  & ((sp_ext + need) > {1'b0, SP_RESET})) |
                   (is_push & (sp_ext < need)));
`else
  assign exc = 1'b0;
`endif

  assign go       = (state == IDLE) & valid_in & ~exc;
  assign complete = (go & ~mem_type_in) | (state == SECOND);

  always_comb begin
    state_nxt  = state;
    sp_nxt     = sp;
    dmem_addr  = first_addr;
    dmem_wdata = first_wdata;
    dmem_we    = 1'b0;
    dmem_re    = 1'b0;
    stall_out  = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          dmem_we = wr;
          dmem_re = rd;
          if (mem_type_in) begin
            stall_out = 1'b1;
            state_nxt = SECOND;
          end else if (is_push) begin
            sp_nxt = sp - ONE;
          end else if (is_pop) begin
            sp_nxt = sp + ONE;
          end
        end
      end
      SECOND: begin
        dmem_addr  = second_addr;
        dmem_wdata = second_wdata;
        dmem_we    = wr;
        dmem_re    = rd;
        state_nxt  = IDLE;
        if (is_push)     sp_nxt = sp - TWO;
        else if (is_pop) sp_nxt = sp + TWO;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      dmem_we   = 1'b0;
      stall_out = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      sp                <= SP_RESET;
      wb_valid_out      <= 1'b0;
      reglow_write_out  <= 1'b0;
      reghigh_write_out <= 1'b0;
      memToReg_out      <= 1'b0;
      Rdst1_out         <= '0;
      Rdst2_out         <= '0;
      Rdst1_val_out     <= '0;
      Rdst2_val_out     <= '0;
      mem_data_out      <= '0;
      POP_flags_val_out <= '0;
      is_POP_flags_out  <= 1'b0;
      pop_pc_out        <= '0;
      pop_pc_valid_out  <= 1'b0;
    end else begin
      state            <= state_nxt;
      sp               <= sp_nxt;
      wb_valid_out     <= complete;
      is_POP_flags_out <= 1'b0;
      pop_pc_valid_out <= 1'b0;
      if (complete) begin
        reglow_write_out  <= reglow_write_in;
        reghigh_write_out <= reghigh_write_in;
        memToReg_out      <= memToReg_in;
        Rdst1_out         <= Rdst1_in;
        Rdst2_out         <= Rdst2_in;
        Rdst1_val_out     <= Rdst1_val_in;
        Rdst2_val_out     <= Rdst2_val_in;
        mem_data_out      <= rd ? dmem_rdata : 16'h0000;
        // Flags live in the top three bits of the last word read (high word for a double pop)
        if (is_pop & rd & flags_push_pop_in) begin
          POP_flags_val_out <= dmem_rdata[15:13];
          is_POP_flags_out  <= 1'b1;
        end
      end
      if ((state == SECOND) & is_pop & rd & mem_data_src_in) begin
        pop_pc_out       <= {3'b000, dmem_rdata[12:0], low_word_p1};
        pop_pc_valid_out <= 1'b1;
      end
    end
  end

  // ---- stage p1: low word of a double read, held for the SECOND cycle ----
  always_ff @(posedge clk) begin
    if (go & mem_type_in & rd) low_word_p1 <= dmem_rdata;
  end

`ifdef STACK_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) stack_exc_out <= 1'b0;
    else       stack_exc_out <= exc;
  end
`else
  assign stack_exc_out = 1'b0;
`endif

  assign SP_out = sp;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a behavioural 4K x 16 data memory.
module tb_mem_access_stage;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic reset;
  logic valid_in, mem_read_in, mem_write_in, mem_type_in;
  logic [1:0] SP_src_in;
  logic mem_addr_src_in, mem_data_src_in, flags_push_pop_in;
  logic [15:0] Rsrc_val_in, Rdst_val_in, Rdst1_val_in, Rdst2_val_in;
  logic [31:0] PC_in;
  logic [2:0] Rdst1_in, Rdst2_in;
  logic reglow_write_in, reghigh_write_in, memToReg_in;
  logic [ADDR_W-1:0] dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic dmem_we, dmem_re, stall_out;
  logic wb_valid_out, reglow_write_out, reghigh_write_out, memToReg_out;
  logic [2:0] Rdst1_out, Rdst2_out;
  logic [15:0] Rdst1_val_out, Rdst2_val_out, mem_data_out;
  logic [2:0] POP_flags_val_out;
  logic is_POP_flags_out, pop_pc_valid_out, stack_exc_out;
  logic [31:0] pop_pc_out;
  logic [ADDR_W-1:0] SP_out;

  logic [15:0] mem [0:(1<<ADDR_W)-1];
  logic tb_we;
  logic [ADDR_W-1:0] tb_addr;
  logic [15:0] tb_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr] <= dmem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end
  assign dmem_rdata = mem[dmem_addr];

  mem_access_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_type_in(mem_type_in),
    .SP_src_in(SP_src_in), .mem_addr_src_in(mem_addr_src_in), .mem_data_src_in(mem_data_src_in),
    .flags_push_pop_in(flags_push_pop_in), .Rsrc_val_in(Rsrc_val_in), .Rdst_val_in(Rdst_val_in),
    .PC_in(PC_in), .Rdst1_val_in(Rdst1_val_in), .Rdst2_val_in(Rdst2_val_in),
    .Rdst1_in(Rdst1_in), .Rdst2_in(Rdst2_in), .reglow_write_in(reglow_write_in),
    .reghigh_write_in(reghigh_write_in), .memToReg_in(memToReg_in),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata), .stall_out(stall_out), .wb_valid_out(wb_valid_out),
    .reglow_write_out(reglow_write_out), .reghigh_write_out(reghigh_write_out),
    .memToReg_out(memToReg_out), .Rdst1_out(Rdst1_out), .Rdst2_out(Rdst2_out),
    .Rdst1_val_out(Rdst1_val_out), .Rdst2_val_out(Rdst2_val_out), .mem_data_out(mem_data_out),
    .POP_flags_val_out(POP_flags_val_out), .is_POP_flags_out(is_POP_flags_out),
    .pop_pc_out(pop_pc_out), .pop_pc_valid_out(pop_pc_valid_out), .SP_out(SP_out),
    .stack_exc_out(stack_exc_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    valid_in = 0; mem_read_in = 0; mem_write_in = 0; mem_type_in = 0;
    SP_src_in = 2'd0; mem_addr_src_in = 0; mem_data_src_in = 0; flags_push_pop_in = 0;
    Rsrc_val_in = 0; Rdst_val_in = 0; PC_in = 0; Rdst1_val_in = 0; Rdst2_val_in = 0;
    Rdst1_in = 0; Rdst2_in = 0; reglow_write_in = 0; reghigh_write_in = 0; memToReg_in = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    reset = 1; tb_we = 1; tb_addr = 12'h010; tb_data = 16'h5A5A;
    // Push presented during reset must not reach memory
    valid_in = 1; mem_write_in = 1; SP_src_in = 2'd1; Rdst_val_in = 16'hDEAD;
    #1;
    check("reset_we", dmem_we, 0);
    check("reset_stall", stall_out, 0);
    step();
    tb_we = 0;
    step();
    check("reset_sp", SP_out, 12'hFFF);
    check("reset_wb_valid", wb_valid_out, 0);
    check("reset_pop_pc_valid", pop_pc_valid_out, 0);
    check("reset_stack_exc", stack_exc_out, 0);
    check("reset_mem_data", mem_data_out, 0);
    reset = 0; clear_in();

    // Single push of Rdst_val
    valid_in = 1; mem_write_in = 1; SP_src_in = 2'd1; Rdst_val_in = 16'hABCD;
    Rdst1_val_in = 16'h1111; Rdst1_in = 3'd3; reglow_write_in = 1;
    #1;
    check("push1_stall", stall_out, 0);
    check("push1_addr", dmem_addr, 12'hFFF);
    check("push1_we", dmem_we, 1);
    step(); clear_in();
    check("push1_mem", mem[12'hFFF], 16'hABCD);
    check("push1_sp", SP_out, 12'hFFE);
    check("push1_wb_valid", wb_valid_out, 1);
    check("push1_rdst1_val", Rdst1_val_out, 16'h1111);
    check("push1_rdst1", Rdst1_out, 3'd3);
    check("push1_stall_after", stall_out, 0);

    // Double push of PC
    valid_in = 1; mem_write_in = 1; SP_src_in = 2'd1; mem_type_in = 1; mem_data_src_in = 1;
    PC_in = 32'hA000_1234;
    #1;
    check("pushpc_stall1", stall_out, 1);
    check("pushpc_addr1", dmem_addr, 12'hFFE);
    check("pushpc_wdata1", dmem_wdata, 16'hA000);
    step();
    check("pushpc_stall2", stall_out, 0);
    check("pushpc_addr2", dmem_addr, 12'hFFD);
    check("pushpc_wdata2", dmem_wdata, 16'h1234);
    check("pushpc_sp_mid", SP_out, 12'hFFE);
    check("pushpc_wb_mid", wb_valid_out, 0);
    step(); clear_in();
    check("pushpc_mem_hi", mem[12'hFFE], 16'hA000);
    check("pushpc_mem_lo", mem[12'hFFD], 16'h1234);
    check("pushpc_sp", SP_out, 12'hFFC);
    check("pushpc_wb_valid", wb_valid_out, 1);

    // Double pop of PC with flags
    valid_in = 1; mem_read_in = 1; SP_src_in = 2'd2; mem_type_in = 1; mem_data_src_in = 1;
    flags_push_pop_in = 1;
    #1;
    check("poppc_stall1", stall_out, 1);
    check("poppc_addr1", dmem_addr, 12'hFFD);
    check("poppc_re1", dmem_re, 1);
    step();
    check("poppc_stall2", stall_out, 0);
    check("poppc_addr2", dmem_addr, 12'hFFE);
    check("poppc_pcvalid_mid", pop_pc_valid_out, 0);
    step(); clear_in();
    check("poppc_pc", pop_pc_out, 32'h0000_1234);
    check("poppc_pcvalid", pop_pc_valid_out, 1);
    check("poppc_flags", POP_flags_val_out, 3'b101);
    check("poppc_flags_pulse", is_POP_flags_out, 1);
    check("poppc_sp", SP_out, 12'hFFE);
    step();
    check("poppc_pcvalid_end", pop_pc_valid_out, 0);
    check("poppc_flags_end", is_POP_flags_out, 0);

    // Load from Rsrc_val address
    valid_in = 1; mem_read_in = 1; mem_addr_src_in = 1; Rsrc_val_in = 16'h0010; memToReg_in = 1;
    #1;
    check("load_addr", dmem_addr, 12'h010);
    check("load_stall", stall_out, 0);
    step(); clear_in();
    check("load_data", mem_data_out, 16'h5A5A);
    check("load_wb_valid", wb_valid_out, 1);
    check("load_memtoreg", memToReg_out, 1);
    check("load_sp", SP_out, 12'hFFE);
    step();
    check("load_wb_valid_end", wb_valid_out, 0);

    // Reset in the SECOND cycle of a double push
    valid_in = 1; mem_write_in = 1; SP_src_in = 2'd1; mem_type_in = 1; mem_data_src_in = 1;
    PC_in = 32'h1357_2468;
    step();
    reset = 1;
    #1;
    check("rst2_we", dmem_we, 0);
    check("rst2_stall", stall_out, 0);
    step(); reset = 0; clear_in();
    check("rst2_mem_hi", mem[12'hFFE], 16'h1357);
    check("rst2_mem_lo_kept", mem[12'hFFD], 16'h1234);
    check("rst2_sp", SP_out, 12'hFFF);
    check("rst2_wb_valid", wb_valid_out, 0);

    // Pop on an empty stack
    valid_in = 1; mem_read_in = 1; SP_src_in = 2'd2;
    #1;
    check("empty_pop_we", dmem_we, 0);
    step(); clear_in();
`ifdef STACK_CHECK_EN
    check("empty_pop_exc", stack_exc_out, 1);
    check("empty_pop_sp", SP_out, 12'hFFF);
    check("empty_pop_wb", wb_valid_out, 0);
    step();
    check("empty_pop_exc_end", stack_exc_out, 0);
`else
    check("empty_pop_exc", stack_exc_out, 0);
    check("empty_pop_sp_wrap", SP_out, 12'h000);
    check("empty_pop_wb", wb_valid_out, 1);
`endif

    // Single push then single pop with flags
    reset = 1; step(); reset = 0;
    valid_in = 1; mem_write_in = 1; SP_src_in = 2'd1; Rdst_val_in = 16'hC000;
    step(); clear_in();
    check("flagpush_sp", SP_out, 12'hFFE);
    valid_in = 1; mem_read_in = 1; SP_src_in = 2'd2; flags_push_pop_in = 1;
    #1;
    check("flagpop_addr", dmem_addr, 12'hFFF);
    step(); clear_in();
    check("flagpop_flags", POP_flags_val_out, 3'b110);
    check("flagpop_pulse", is_POP_flags_out, 1);
    check("flagpop_data", mem_data_out, 16'hC000);
    check("flagpop_sp", SP_out, 12'hFFF);
    check("flagpop_no_pc", pop_pc_valid_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
